// File: rtl/sram1rw_ctrl.sv
// sram1rw_ctrl: valid/ready front end for a 1RW SRAM macro, with an optional post-reset clear sweep.
// Reads return 2 cycles after accept through a 2-entry FWFT FIFO. Reads stall when FIFO plus inflight would exceed 2; writes never stall.
module sram1rw_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign o_vld   = (r_count != 2'd0);
  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_pop   = i_pop && o_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // The controller's credit check must make this unreachable.
  assert property (@(posedge clk) disable iff (reset) !(i_push && (r_count == 2'd2) && !w_pop));
endmodule

module sram1rw_ctrl #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 128,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [DATA_WIDTH-1:0] sram_i,
  input  logic [DATA_WIDTH-1:0] sram_o
);
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ic;
  logic                  r_init_done;
  logic                  r_inflight;
  logic                  w_run;
  logic                  w_pop;
  logic                  w_hs;
  logic [1:0]            w_count;
  logic [2:0]            w_occ;

  assign w_run     = (r_state == ST_RUN);
  assign w_pop     = rsp_valid && rsp_ready;
  // A pop this cycle frees a slot in time for a read accepted on the same edge.
  assign w_occ     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign req_ready = w_run && (req_we || (w_occ < 3'd2));
  assign w_hs      = req_valid && req_ready;
  assign init_done = r_init_done;
  assign sram_oeb  = 1'b0;

  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_a   = req_addr;
    sram_i   = req_wdata;
    if (!w_run) begin
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_a   = r_ic;
      sram_i   = INIT_VALUE;
    end else if (w_hs) begin
      sram_csb = 1'b0;
      sram_web = ~req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT_EN ? ST_INIT : ST_RUN;
      r_ic        <= '0;
      r_init_done <= !INIT_EN;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_hs && !req_we;
      case (r_state)
        ST_INIT: begin
          r_ic <= r_ic + ADDR_WIDTH'(1);
          if (r_ic == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Macro read data is valid exactly one edge after the read was accepted.
  sram1rw_fifo2 #(.W(DATA_WIDTH)) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_dat   (sram_o),
    .i_pop   (w_pop),
    .o_vld   (rsp_valid),
    .o_dat   (rsp_rdata),
    .o_count (w_count)
  );
endmodule
